div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Multi-cycle integer divide/remainder unit for DIV/DIVU/REM/REMU.
//   - Consumes operand data read from the register file (r1Data/r2Data).
//   - Produces a single-cycle write-back (wEn/wAddr/wData) that drives the
//     register file write port directly.
//   - Raises busy so the control path stalls the PC while a divide is in flight.
// PARAMETERS
//   RegisterWidth  32  operand/result width in bits (XLEN)
//   NRegisters     32  register count; AddrWidth = $clog2(NRegisters)
// PORTS
//   clk      in   1              clock; all state updates on posedge
//   reset    in   1              synchronous, active-high
//   start    in   1              request a divide; sampled only in IDLE
//   op       in   2              00 DIV, 01 DIVU, 10 REM, 11 REMU
//   r1Data   in   RegisterWidth  dividend
//   r2Data   in   RegisterWidth  divisor
//   rdAddr   in   AddrWidth      destination register
//   busy     out  1              high in RUN and DONE
//   wEn      out  1              one-cycle write-back strobe
//   wAddr    out  AddrWidth      write-back register address
//   wData    out  RegisterWidth  write-back result
// BEHAVIOUR
//   Reset and outputs
//   - One clock (clk); reset is synchronous and active-high. Reset takes
//     priority over every other input.
//   - Reset forces state=IDLE, busy=0, wEn=0, wAddr=0, wData=0, and clears
//     all internal registers.
//   - All outputs are registered.
//   FSM: IDLE -> RUN -> DONE -> IDLE
//   - IDLE, start=1 at edge E0:
//     - Latch op and rdAddr.
//     - Latch |r1Data| and |r2Data|. Absolute values apply only for the
//       signed ops (DIV, REM); DIVU and REMU use the raw operands.
//     - Latch the quotient and remainder sign flags.
//     - Set count=RegisterWidth and go to RUN.
//   - IDLE, start=0: hold state. busy=0, wEn=0.
//   - RUN: one restoring shift-subtract iteration per edge, decrement count.
//     - At edge E0+RegisterWidth the final iteration completes.
//     - On that same edge, apply sign fixup, load wData and wAddr=rdAddr,
//       set wEn=1, and go to DONE.
//   - DONE: wEn=1 for exactly one cycle, so the register file writes at edge
//     E0+RegisterWidth+1. That edge also returns the FSM to IDLE with wEn=0.
//   - busy is high from E0+1 through E0+RegisterWidth+1, i.e. RegisterWidth+1
//     cycles.
//   Handshake
//   - start is ignored while busy=1; no queueing.
//   - A new start is accepted on the edge after DONE, i.e. the first IDLE cycle.
//   Result rules (RISC-V)
//   - Signed quotient is negative iff the operand signs differ.
//   - Signed remainder takes the sign of the dividend.
//   - Divide by zero: quotient = all ones; remainder = dividend. Applies to
//     both signed and unsigned ops.
//   - Signed overflow (dividend = 0x80000000, divisor = -1): quotient =
//     0x80000000, remainder = 0.
//   - Special cases still use the full fixed latency; latency is constant.
//   - rdAddr=0 still pulses wEn with wAddr=0. The register file discards
//     writes to x0.
//   Other boundaries
//   - Operands and rdAddr are latched at E0. Changes on r1Data/r2Data/rdAddr
//     while busy have no effect.
//   - Reset during RUN or DONE aborts the divide: no write-back pulse,
//     busy=0 on the next cycle.
//   - wAddr/wData hold their last values while wEn=0.
// TESTING  (RegisterWidth=32; check wEn pulse at cycle E0+33, then the
//           register-file contents)
//   1. DIVU 100/7, rd=5 -> wData=14, wAddr=5. wEn high exactly one cycle;
//      busy high 33 cycles.
//   2. DIV -20/3 -> 0xFFFFFFFA.
//      REM -7/2 -> 0xFFFFFFFF.
//      REMU 0xFFFFFFFF/16 -> 0xF.
//   3. DIVU 5/0 -> 0xFFFFFFFF.
//      REM 5/0 -> 5.
//      DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//      REM of the same operands -> 0.
//   4. start held high and operands changed during RUN -> one write only,
//      with the original result. The next start is accepted the first IDLE
//      cycle after DONE.
//   5. reset asserted at RUN cycle 10 -> busy=0 and wEn=0 next cycle; no
//      write ever occurs; target register unchanged.
//   6. DIV 9/3 with rd=0 -> wEn pulses with wAddr=0; register-file read of
//      x0 returns 0.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a registered
// one-cycle write-back to the register file.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start, op           request (sampled in IDLE); 00 DIV 01 DIVU 10 REM 11 REMU
//   r1Data, r2Data      dividend, divisor
//   rdAddr              destination register
//   busy                high while a divide is in flight (RUN and DONE)
//   wEn, wAddr, wData   one-cycle register-file write-back
module div_unit #(
  parameter int RegisterWidth = 32,
  parameter int NRegisters    = 32,
  localparam int AddrWidth    = $clog2(NRegisters)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [RegisterWidth-1:0] r1Data,
  input  logic [RegisterWidth-1:0] r2Data,
  input  logic [AddrWidth-1:0]     rdAddr,
  output logic                     busy,
  output logic                     wEn,
  output logic [AddrWidth-1:0]     wAddr,
  output logic [RegisterWidth-1:0] wData
);

  localparam int W    = RegisterWidth;
  localparam int CntW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q;
  logic                 is_rem_q;
  logic [AddrWidth-1:0] rd_q;
  logic [W-1:0]         quo_q;
  logic [W-1:0]         rem_q;
  logic [W-1:0]         dvs_q;
  logic [CntW-1:0]      cnt_q;
  logic                 negq_q;
  logic                 negr_q;
  logic                 busy_q;
  logic                 wen_q;
  logic [AddrWidth-1:0] waddr_q;
  logic [W-1:0]         wdata_q;

  // Operand preparation for the start edge
  logic         sgn_op;
  logic         s1;
  logic         s2;
  logic [W-1:0] abs1;
  logic [W-1:0] abs2;

  always_comb begin
    sgn_op = ~op[0];
    s1     = sgn_op & r1Data[W-1];
    s2     = sgn_op & r2Data[W-1];
    abs1   = s1 ? (~r1Data + 1'b1) : r1Data;
    abs2   = s2 ? (~r2Data + 1'b1) : r2Data;
  end

  // One restoring shift-subtract step plus final sign fixup
  logic [W:0]   sh;
  logic [W:0]   diff;
  logic         ge;
  logic [W-1:0] rem_d;
  logic [W-1:0] quo_d;
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;
  logic [W-1:0] res;

  always_comb begin
    sh    = {rem_q, quo_q[W-1]};
    diff  = sh - {1'b0, dvs_q};
    ge    = ~diff[W];
    rem_d = ge ? diff[W-1:0] : sh[W-1:0];
    quo_d = {quo_q[W-2:0], ge};
    q_fix = negq_q ? (~quo_d + 1'b1) : quo_d;
    r_fix = negr_q ? (~rem_d + 1'b1) : rem_d;
    res   = is_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      is_rem_q <= 1'b0;
      rd_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wen_q <= 1'b0;
          if (start) begin
            is_rem_q <= op[1];
            rd_q     <= rdAddr;
            quo_q    <= abs1;
            rem_q    <= '0;
            dvs_q    <= abs2;
            cnt_q    <= CntW'(W);
            // Divide by zero keeps the all-ones quotient unsigned
            negq_q   <= (s1 ^ s2) & (r2Data != '0);
            negr_q   <= s1;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            wdata_q <= res;
            waddr_q <= rd_q;
            wen_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign wEn   = wen_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands against an arithmetic reference and a register-file model.
module tb_div_unit;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] r1Data;
  logic [31:0] r2Data;
  logic [4:0]  rdAddr;
  logic        busy;
  logic        wEn;
  logic [4:0]  wAddr;
  logic [31:0] wData;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .r1Data(r1Data),
    .r2Data(r2Data),
    .rdAddr(rdAddr),
    .busy  (busy),
    .wEn   (wEn),
    .wAddr (wAddr),
    .wData (wData)
  );

  // Register file model fed by the write-back port; x0 is hardwired
  always @(posedge clk) begin
    if (wEn && wAddr != 5'd0) rf[wAddr] <= wData;
  end

  function automatic logic [31:0] ref_div(
    input logic [1:0] o, input logic [31:0] a, input logic [31:0] b
  );
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (o)
      DIVU: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU: ref_div = (b == 0) ? a : a % b;
      DIV: begin
        if (b == 0) ref_div = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_div = a;
        else ref_div = 32'(sa / sb);
      end
      default: begin
        if (b == 0) ref_div = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_div = 0;
        else ref_div = 32'(sa % sb);
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request before edge E0; returns #1 after E0
  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input bit hold);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    r1Data = a;
    r2Data = b;
    rdAddr = rd;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Follow edges E0+1..E0+33 and check timing, result and register file
  task automatic track(input string tag, input logic [31:0] exp,
                       input logic [4:0] rd, input bit scramble);
    int nbusy;
    int nwen;
    nbusy = 0;
    nwen  = 0;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      #1;
      if (busy) nbusy++;
      if (wEn) begin
        nwen++;
        check({tag, "_wen_cycle"}, i, 32);
        check({tag, "_wdata"}, wData, exp);
        check({tag, "_waddr"}, {27'd0, wAddr}, {27'd0, rd});
      end
      if (scramble) begin
        r1Data = $urandom;
        r2Data = $urandom;
        rdAddr = 5'($urandom);
        op     = 2'($urandom);
      end
    end
    check({tag, "_busy_cycles"}, nbusy + 1, 33);
    check({tag, "_wen_pulses"}, nwen, 1);
    check({tag, "_rf"}, rf[rd], (rd == 0) ? 32'd0 : exp);
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd);
    launch(o, a, b, rd, 1'b0);
    track(tag, ref_div(o, a, b), rd, 1'b0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rr;
    int          nwen;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    r1Data = 32'd0;
    r2Data = 32'd0;
    rdAddr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wen", {31'd0, wEn}, 32'd0);
    check("rst_waddr", {27'd0, wAddr}, 32'd0);
    check("rst_wdata", wData, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);

    run("divu_100_7", DIVU, 32'd100, 32'd7, 5'd5);
    check("divu_100_7_val", rf[5], 32'd14);
    run("div_m20_3", DIV, 32'hFFFF_FFEC, 32'd3, 5'd6);
    check("div_m20_3_val", rf[6], 32'hFFFF_FFFA);
    run("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd7);
    check("rem_m7_2_val", rf[7], 32'hFFFF_FFFF);
    run("remu_big_16", REMU, 32'hFFFF_FFFF, 32'd16, 5'd8);
    check("remu_big_16_val", rf[8], 32'hF);
    run("divu_by0", DIVU, 32'd5, 32'd0, 5'd9);
    check("divu_by0_val", rf[9], 32'hFFFF_FFFF);
    run("rem_by0", REM, 32'd5, 32'd0, 5'd10);
    check("rem_by0_val", rf[10], 32'd5);
    run("div_by0_neg", DIV, 32'hFFFF_FFF0, 32'd0, 5'd11);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    check("div_ovf_val", rf[12], 32'h8000_0000);
    run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    check("rem_ovf_val", rf[13], 32'd0);

    // start held high with operands churning, then back-to-back accept
    launch(DIVU, 32'd1000, 32'd10, 5'd14, 1'b1);
    track("hold", 32'd100, 5'd14, 1'b1);
    op     = DIV;
    r1Data = 32'hFFFF_FF9C;
    r2Data = 32'd7;
    rdAddr = 5'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    track("b2b", ref_div(DIV, 32'hFFFF_FF9C, 32'd7), 5'd15, 1'b0);
    check("hold_rf_kept", rf[14], 32'd100);

    // Reset at RUN cycle 10 aborts without a write
    launch(DIVU, 32'd77, 32'd3, 5'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wen", {31'd0, wEn}, 32'd0);
    nwen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (wEn) nwen++;
    end
    check("abort_no_write", nwen, 0);
    check("abort_rf", rf[5], 32'd14);

    run("div_rd0", DIV, 32'd9, 32'd3, 5'd0);
    check("rd0_rf", rf[0], 32'd0);
    check("rd0_hold_wdata", wData, 32'd3);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (n % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (n % 7 == 0) ra = -ra;
      rr = 5'($urandom_range(1, 31));
      run($sformatf("rand%0d", n), ro, ra, rb, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
